// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Multicycle main controller. Sequences each instruction from
//                FETCH through writeback and drives the write requests
//                (PCS/RegW/MemW/NoWrite/FlagW) into the conditional logic,
//                plus datapath mux selects, IR/PC enables and ALUControl.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int STATE_W    = 4,
    parameter int ALU_CTRL_W = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rd,
    output logic                  PCS,
    output logic                  RegW,
    output logic                  MemW,
    output logic                  NoWrite,
    output logic [1:0]            FlagW,
    output logic                  IRWrite,
    output logic                  NextPC,
    output logic                  AdrSrc,
    output logic [1:0]            ResultSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic [STATE_W-1:0]    State
);

    // State encoding; codes above c_BRANCH are illegal and recover to FETCH
    localparam logic [STATE_W-1:0] c_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] c_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] c_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] c_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] c_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] c_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] c_EXECUTER = STATE_W'(6);
    localparam logic [STATE_W-1:0] c_EXECUTEI = STATE_W'(7);
    localparam logic [STATE_W-1:0] c_ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] c_BRANCH   = STATE_W'(9);

    localparam logic [ALU_CTRL_W-1:0] c_ALU_ADD = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] c_ALU_SUB = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] c_ALU_AND = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] c_ALU_ORR = ALU_CTRL_W'(3);

    localparam logic [3:0] c_CMD_AND = 4'b0000;
    localparam logic [3:0] c_CMD_SUB = 4'b0010;
    localparam logic [3:0] c_CMD_ADD = 4'b0100;
    localparam logic [3:0] c_CMD_CMP = 4'b1010;
    localparam logic [3:0] c_CMD_ORR = 4'b1100;

    logic [STATE_W-1:0]    r_state;
    logic [STATE_W-1:0]    w_next_state;
    logic                  w_pcs;
    logic                  w_regw;
    logic                  w_memw;
    logic                  w_irwrite;
    logic                  w_nextpc;
    logic [1:0]            w_flagw;
    logic [ALU_CTRL_W-1:0] w_dec_alu;
    logic                  w_dec_known;
    logic                  w_dec_cv;
    logic                  w_dec_nowrite;
    logic                  w_rd_pc;

    assign w_rd_pc = (Rd == 4'hF);

    // State register; reset returns to FETCH on the edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Data-processing command decode; unsupported commands compute ADD but never write
    always_comb begin
        w_dec_alu     = c_ALU_ADD;
        w_dec_known   = 1'b0;
        w_dec_cv      = 1'b0;
        w_dec_nowrite = 1'b1;
        case (Funct[4:1])
            c_CMD_ADD: begin
                w_dec_alu = c_ALU_ADD; w_dec_known = 1'b1; w_dec_cv = 1'b1; w_dec_nowrite = 1'b0;
            end
            c_CMD_SUB: begin
                w_dec_alu = c_ALU_SUB; w_dec_known = 1'b1; w_dec_cv = 1'b1; w_dec_nowrite = 1'b0;
            end
            c_CMD_AND: begin
                w_dec_alu = c_ALU_AND; w_dec_known = 1'b1; w_dec_nowrite = 1'b0;
            end
            c_CMD_ORR: begin
                w_dec_alu = c_ALU_ORR; w_dec_known = 1'b1; w_dec_nowrite = 1'b0;
            end
            c_CMD_CMP: begin
                w_dec_alu = c_ALU_SUB; w_dec_known = 1'b1; w_dec_cv = 1'b1; w_dec_nowrite = 1'b1;
            end
            default: begin
                w_dec_alu = c_ALU_ADD;
            end
        endcase
    end

    // Next-state and per-state Moore outputs
    always_comb begin
        w_next_state = c_FETCH;
        w_pcs        = 1'b0;
        w_regw       = 1'b0;
        w_memw       = 1'b0;
        w_irwrite    = 1'b0;
        w_nextpc     = 1'b0;
        w_flagw      = 2'b00;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUControl   = c_ALU_ADD;
        case (r_state)
            c_FETCH: begin
                w_next_state = c_DECODE;
                w_irwrite    = 1'b1;
                w_nextpc     = 1'b1;
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
            end
            c_DECODE: begin
                // PC+8 is presented as R15 while registers are read
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   w_next_state = Funct[5] ? c_EXECUTEI : c_EXECUTER;
                    2'b01:   w_next_state = c_MEMADR;
                    2'b10:   w_next_state = c_BRANCH;
                    default: w_next_state = c_FETCH;
                endcase
            end
            c_MEMADR: begin
                w_next_state = Funct[0] ? c_MEMREAD : c_MEMWRITE;
                ALUSrcB      = 2'b01;
            end
            c_MEMREAD: begin
                w_next_state = c_MEMWB;
                AdrSrc       = 1'b1;
            end
            c_MEMWB: begin
                ResultSrc = 2'b01;
                w_regw    = 1'b1;
                w_pcs     = w_rd_pc;
            end
            c_MEMWRITE: begin
                AdrSrc = 1'b1;
                w_memw = 1'b1;
            end
            c_EXECUTER, c_EXECUTEI: begin
                w_next_state = c_ALUWB;
                ALUSrcB      = (r_state == c_EXECUTEI) ? 2'b01 : 2'b00;
                ALUControl   = w_dec_alu;
                w_flagw      = w_dec_known ? {Funct[0], Funct[0] & w_dec_cv} : 2'b00;
            end
            c_ALUWB: begin
                w_regw = 1'b1;
                w_pcs  = w_rd_pc;
            end
            c_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcs     = 1'b1;
            end
            default: begin
                w_next_state = c_FETCH;
            end
        endcase
    end

    // Reset suppresses every architectural write so an abandoned instruction leaves no trace
    assign PCS     = w_pcs     & ~Reset;
    assign RegW    = w_regw    & ~Reset;
    assign MemW    = w_memw    & ~Reset;
    assign IRWrite = w_irwrite & ~Reset;
    assign NextPC  = w_nextpc  & ~Reset;
    assign FlagW   = w_flagw   & {2{~Reset}};
    assign NoWrite = w_dec_nowrite;
    assign ImmSrc  = Op;
    assign RegSrc  = {(Op == 2'b01), (Op == 2'b10)};
    assign State   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_fsm
//  Description : Self-checking bench for multicycle_control_fsm. Directed and
//                random instructions compared against an instruction-level
//                reference model, with occasional mid-instruction resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       PCS, RegW, MemW, NoWrite, IRWrite, NextPC, AdrSrc, ALUSrcA;
    logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0] State;

    int checks   = 0;
    int failures = 0;

    multicycle_control_fsm #(.STATE_W(4), .ALU_CTRL_W(2)) dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .FlagW(FlagW),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
    );

    // Free-running clock
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // State visited at step k of an instruction, listed per instruction class
    function automatic int path_state(input logic [1:0] op, input logic [5:0] f, input int k);
        int p[5];
        if (op == 2'b00 && f[5])       p = '{0, 1, 7, 8, 0};
        else if (op == 2'b00)          p = '{0, 1, 6, 8, 0};
        else if (op == 2'b01 && f[0])  p = '{0, 1, 2, 3, 4};
        else if (op == 2'b01)          p = '{0, 1, 2, 5, 0};
        else if (op == 2'b10)          p = '{0, 1, 9, 0, 0};
        else                           p = '{0, 1, 0, 0, 0};
        return p[k];
    endfunction

    // Cycles per instruction: BR 3, DP 4, STR 4, LDR 5, undefined 2
    function automatic int path_len(input logic [1:0] op, input logic [5:0] f);
        case (op)
            2'b00:   return 4;
            2'b01:   return f[0] ? 5 : 4;
            2'b10:   return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic exp_nowrite(input logic [5:0] f);
        int cmd;
        cmd = int'(f[4:1]);
        return !(cmd == 4 || cmd == 2 || cmd == 0 || cmd == 12);
    endfunction

    // Expected output bundle {PCS,RegW,MemW,FlagW,IRWrite,NextPC,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegSrc}
    function automatic logic [18:0] model(input int st, input logic rst, input logic [1:0] op,
                                          input logic [5:0] f, input logic [3:0] rd);
        logic pcs, regw, memw, irw, npc, adr, sa;
        logic [1:0] fw, rs, sb, ac;
        int cmd;
        logic s, is_add, is_sub, is_and, is_orr, is_cmp, known;
        pcs = 0; regw = 0; memw = 0; irw = 0; npc = 0; adr = 0; sa = 0;
        fw = 0; rs = 0; sb = 0; ac = 0;
        cmd = int'(f[4:1]);
        s = f[0];
        is_add = (cmd == 4); is_sub = (cmd == 2); is_and = (cmd == 0);
        is_orr = (cmd == 12); is_cmp = (cmd == 10);
        known = is_add | is_sub | is_and | is_orr | is_cmp;
        case (st)
            0: begin irw = 1; npc = 1; sa = 1; sb = 2; rs = 2; end
            1: begin sa = 1; sb = 2; rs = 2; end
            2: sb = 1;
            3: adr = 1;
            4: begin rs = 1; regw = 1; pcs = (rd == 4'd15); end
            5: begin adr = 1; memw = 1; end
            6, 7: begin
                sb = (st == 7) ? 2'd1 : 2'd0;
                ac = (is_sub | is_cmp) ? 2'd1 : is_and ? 2'd2 : is_orr ? 2'd3 : 2'd0;
                fw = known ? {s, s & (is_add | is_sub | is_cmp)} : 2'b00;
            end
            8: begin regw = 1; pcs = (rd == 4'd15); end
            9: begin sb = 1; rs = 2; pcs = 1; end
            default: ;
        endcase
        if (rst) begin
            pcs = 0; regw = 0; memw = 0; fw = 0; irw = 0; npc = 0;
        end
        return {pcs, regw, memw, fw, irw, npc, adr, rs, sa, sb, ac, op, (op == 2'b01), (op == 2'b10)};
    endfunction

    function automatic logic [18:0] observed();
        return {PCS, RegW, MemW, FlagW, IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, RegSrc};
    endfunction

    // Runs one instruction starting in FETCH; optionally asserts Reset after step rst_at
    task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                             input int rst_at);
        int st;
        Op = op; Funct = f; Rd = rd;
        #1;
        for (int k = 0; k < path_len(op, f); k++) begin
            if (k > 0) begin
                @(posedge Clk); #1;
            end
            st = path_state(op, f, k);
            check_eq($sformatf("state op%0d f%0h step%0d", op, f, k), 32'(State), 32'(st));
            check_eq($sformatf("outs op%0d f%0h st%0d", op, f, st), 32'(observed()),
                     32'(model(st, 1'b0, op, f, rd)));
            if (k > 0)
                check_eq($sformatf("nowrite f%0h st%0d", f, st), 32'(NoWrite), 32'(exp_nowrite(f)));
            if (k == rst_at) begin
                Reset = 1'b1;
                #1;
                check_eq($sformatf("rst outs st%0d", st), 32'(observed()),
                         32'(model(st, 1'b1, op, f, rd)));
                @(posedge Clk); #1;
                check_eq("rst state", 32'(State), 32'd0);
                check_eq("rst fetch outs", 32'(observed()), 32'(model(0, 1'b1, op, f, rd)));
                Reset = 1'b0;
                #1;
                check_eq("post rst fetch", 32'(observed()), 32'(model(0, 1'b0, op, f, rd)));
                return;
            end
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        int rst_at;
        logic [1:0] rop;
        logic [5:0] rf;
        logic [3:0] rrd;
        Reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
        repeat (2) begin
            @(posedge Clk); #1;
            check_eq("reset state", 32'(State), 32'd0);
            check_eq("reset outs", 32'(observed()), 32'(model(0, 1'b1, Op, Funct, Rd)));
        end
        Reset = 1'b0;
        #1;
        check_eq("first fetch IRWrite", 32'(IRWrite), 32'd1);
        check_eq("first fetch NextPC", 32'(NextPC), 32'd1);

        run_instr(2'b00, 6'b001001, 4'd3,  -1);  // ADDS register
        run_instr(2'b00, 6'b110101, 4'd2,  -1);  // CMP immediate
        run_instr(2'b01, 6'b011001, 4'd15, -1);  // LDR to PC
        run_instr(2'b01, 6'b011000, 4'd4,  -1);  // STR
        run_instr(2'b10, 6'b100000, 4'd0,  -1);  // branch
        run_instr(2'b11, 6'b000000, 4'd0,  -1);  // undefined
        run_instr(2'b00, 6'b000001, 4'd5,  -1);  // ANDS: NZ only
        run_instr(2'b00, 6'b001101, 4'd6,  -1);  // unsupported cmd
        run_instr(2'b00, 6'b011000, 4'd15, -1);  // ORR to PC
        run_instr(2'b01, 6'b011000, 4'd1,  3);   // reset during MEMWRITE

        for (int i = 0; i < 80; i++) begin
            rop = 2'($urandom_range(0, 3));
            rf  = 6'($urandom);
            rrd = 4'($urandom);
            rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(rop, rf, rrd, rst_at);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
